// File: rtl/fu_arbiter.sv
`timescale 1ns/1ps
// Two-client round-robin arbiter with bounded lock bursts in front of a shared
// combinational Functional_Unit; operands and result are each registered once.
module fu_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [7:0] instr0,
  input  logic [7:0] instr1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] c0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [7:0] c1,
  input  logic [2:0] sel0,
  input  logic [2:0] sel1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       res_valid0,
  output logic       res_valid1,
  output logic [7:0] result
);
  localparam logic [2:0] HOLD_LIM = 3'(HOLD_MAX);
  localparam logic [2:0] HOLD_SAT = 3'd7;

  logic [1:0] req_vec;
  logic [1:0] gnt_vec;
  logic       accept;
  logic       win;
  logic       lock_win;
  logic       prio_reg, prio_next;
  logic       owner_reg, owner_next;
  logic [2:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0] op_instr_reg, op_a_reg, op_b_reg, op_c_reg;
  logic [2:0] op_sel_reg;
  logic       iss_v_reg;
  logic       iss_id_reg;
  logic [7:0] fu_out;
  logic [7:0] result_reg;

  assign req_vec = {req1, req0};

  // Grant depends only on requests, priority and reset, never on operands.
  always_comb begin
    gnt_vec = 2'b00;
    if (rst_n) begin
      if (&req_vec) gnt_vec[prio_reg] = 1'b1;
      else          gnt_vec = req_vec;
    end
  end

  assign gnt0     = gnt_vec[0];
  assign gnt1     = gnt_vec[1];
  assign accept   = |gnt_vec;
  assign win      = gnt_vec[1];
  assign lock_win = win ? lock1 : lock0;

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    owner_next    = owner_reg;
    prio_next     = prio_reg;
    if (accept) begin
      if (!lock_win)
        hold_cnt_next = 3'd0;
      else if (owner_reg == win && hold_cnt_reg != 3'd0)
        hold_cnt_next = (hold_cnt_reg == HOLD_SAT) ? HOLD_SAT : hold_cnt_reg + 3'd1;
      else
        hold_cnt_next = 3'd1;
      owner_next = win;
      // Keep priority with a locking owner until its burst reaches the bound.
      prio_next  = (lock_win && hold_cnt_next < HOLD_LIM) ? win : ~win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg     <= 1'b0;
      owner_reg    <= 1'b0;
      hold_cnt_reg <= 3'd0;
    end else begin
      prio_reg     <= prio_next;
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_instr_reg <= 8'd0;
      op_a_reg     <= 8'd0;
      op_b_reg     <= 8'd0;
      op_c_reg     <= 8'd0;
      op_sel_reg   <= 3'd0;
      iss_v_reg    <= 1'b0;
      iss_id_reg   <= 1'b0;
    end else begin
      iss_v_reg <= accept;
      if (accept) begin
        op_instr_reg <= win ? instr1 : instr0;
        op_a_reg     <= win ? a1 : a0;
        op_b_reg     <= win ? b1 : b0;
        op_c_reg     <= win ? c1 : c0;
        op_sel_reg   <= win ? sel1 : sel0;
        iss_id_reg   <= win;
      end
    end
  end

  Functional_Unit u_fu (
    .instr (op_instr_reg),
    .a     (op_a_reg),
    .b     (op_b_reg),
    .c     (op_c_reg),
    .sel   (op_sel_reg),
    .f     (fu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         result_reg <= 8'd0;
    else if (iss_v_reg) result_reg <= fu_out;
  end

  assign result = result_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : gen_rv
    logic rv_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rv_reg <= 1'b0;
      else        rv_reg <= iss_v_reg && (iss_id_reg == 1'(gi));
    end
  end

  assign res_valid0 = gen_rv[0].rv_reg;
  assign res_valid1 = gen_rv[1].rv_reg;
endmodule

// Shared combinational unit: sel picks an 8-bit operation on A/B/C and the
// instruction byte is XOR-folded into the outcome.
module Functional_Unit (
  input  logic [7:0] instr,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [2:0] sel,
  output logic [7:0] f
);
  logic [7:0] base;

  always_comb begin
    base = 8'd0;
    case (sel)
      3'd0: base = a + b;
      3'd1: base = a - b;
      3'd2: base = a & b;
      3'd3: base = a | b;
      3'd4: base = a ^ b;
      3'd5: base = a + b + c;
      3'd6: base = a * b;
      3'd7: base = c - a;
      default: base = 8'd0;
    endcase
    f = base ^ instr;
  end
endmodule

// File: tb/tb_fu_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for fu_arbiter: the stimulus side checks grants and queues
// the expected result; an independent monitor matches every result strobe.
module tb_fu_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [7:0] instr0 = '0, instr1 = '0;
  logic [7:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
  logic [2:0] sel0 = '0, sel1 = '0;
  logic       gnt0, gnt1, res_valid0, res_valid1;
  logic [7:0] result;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fu_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .instr0(instr0), .instr1(instr1),
    .a0(a0), .b0(b0), .c0(c0), .a1(a1), .b1(b1), .c1(c1),
    .sel0(sel0), .sel1(sel1),
    .gnt0(gnt0), .gnt1(gnt1),
    .res_valid0(res_valid0), .res_valid1(res_valid1),
    .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fu_model(input logic [7:0] i, a, b, c, input logic [2:0] s);
    logic [7:0] r;
    case (s)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a + b + c;
      3'd6: r = a * b;
      default: r = c - a;
    endcase
    return r ^ i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input int cl, input logic [7:0] i, a, b, c, input logic [2:0] s);
    if (cl == 0) begin instr0 = i; a0 = a; b0 = b; c0 = c; sel0 = s; end
    else         begin instr1 = i; a1 = a; b1 = b; c1 = c; sel1 = s; end
  endtask

  // One cycle: check grants at the negedge, queue the expected result, advance.
  task automatic step(input string tag, input logic e0, input logic e1);
    @(negedge clk);
    chk({tag, "_gnt0"}, gnt0, e0);
    chk({tag, "_gnt1"}, gnt1, e1);
    if (req0 && gnt0)
      sb.push_back('{1'b0, fu_model(instr0, a0, b0, c0, sel0), cyc + 2});
    else if (req1 && gnt1)
      sb.push_back('{1'b1, fu_model(instr1, a1, b1, c1, sel1), cyc + 2});
    $display("cycle %0d %s req=%b%b gnt=%b%b", cyc, tag, req1, req0, gnt1, gnt0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    repeat (n) step("idle", 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"}, gnt0, 1'b0);
    chk({tag, "_gnt1"}, gnt1, 1'b0);
    chk({tag, "_rv0"}, res_valid0, 1'b0);
    chk({tag, "_rv1"}, res_valid1, 1'b0);
    chk({tag, "_result"}, result, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every strobe must match the head of the queue, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid0 || res_valid1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=rv%b%b/%0h required=none", res_valid1, res_valid0, result);
        end else begin
          e = sb.pop_front();
          chk("res_valid", {res_valid1, res_valid0}, e.id ? 2'b10 : 2'b01);
          chk("result", result, e.data);
          chk("latency", cyc, e.due);
          $display("cycle %0d result client=%0d data=%0h", cyc, e.id, result);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_result actual=none required=client%0d/%0h", e.id, e.data);
      end
    end
  end

  initial begin
    logic [9:0] lock_pat;
    lock_pat = 10'b10_0001_0000;  // bit i set: grant i goes to client 1

    // Reset state, with both clients already requesting.
    req0 = 1'b1; req1 = 1'b1;
    #2 chk_zero("por");
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single op on an idle arbiter: (0x12 | 0x34) ^ 0x01 = 0x37.
    set_ops(0, 8'h01, 8'h12, 8'h34, 8'h56, 3'd3);
    req0 = 1'b1;
    @(negedge clk);
    chk("single_gnt0", gnt0, 1'b1);
    chk("single_gnt1", gnt1, 1'b0);
    sb.push_back('{1'b0, 8'h37, cyc + 2});
    @(posedge clk); #1;
    req0 = 1'b0;
    idle(4);

    // Full contention without lock alternates, client 0 first.
    do_reset();
    set_ops(0, 8'h00, 8'h10, 8'h05, 8'h00, 3'd0);
    set_ops(1, 8'hF0, 8'h0F, 8'h33, 8'h44, 3'd5);
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) step("contend", (i % 2) == 0, (i % 2) == 1);
    idle(4);

    // Lock bound of four grants under contention.
    do_reset();
    set_ops(0, 8'h55, 8'h07, 8'h09, 8'h00, 3'd6);
    set_ops(1, 8'h0A, 8'h80, 8'h01, 8'h02, 3'd1);
    req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1;
    for (int i = 0; i < 10; i++) step("lock", !lock_pat[i], lock_pat[i]);
    idle(4);

    // Lone locked requester runs past the bound; hold count saturates.
    do_reset();
    set_ops(1, 8'h3C, 8'hAA, 8'h55, 8'h11, 3'd4);
    set_ops(0, 8'h00, 8'h20, 8'h00, 8'h30, 3'd7);
    req1 = 1'b1; lock1 = 1'b1;
    for (int i = 0; i < 10; i++) step("lone", 1'b0, 1'b1);
    chk("hold_sat", dut.hold_cnt_reg, 3'd7);
    req0 = 1'b1;
    step("after_lone", 1'b1, 1'b0);
    idle(4);

    // Back-to-back from client 0 with fresh operands each cycle.
    req0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_ops(0, 8'(i * 17), 8'(8'h21 + i * 3), 8'(8'h0B + i), 8'(8'hC0 - i), 3'(i));
      step("b2b", 1'b1, 1'b0);
    end
    idle(4);

    // Reset right after an accept discards the in-flight op.
    set_ops(0, 8'h99, 8'h01, 8'h02, 8'h03, 3'd0);
    req0 = 1'b1;
    step("mid", 1'b1, 1'b0);
    req1 = 1'b1;
    rst_n = 1'b0;
    sb.delete();
    #1 chk_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_reset", 1'b1, 1'b0);
    idle(5);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
